// File: rtl/ast_width_downsizer_pkg.sv
// Shared widths, derived empty widths, typedefs and state encoding for the
// Avalon-ST width converters.
package ast_conv_pkg;

   localparam int DATA_IN_W   = 128;
   localparam int DATA_OUT_W  = 64;
   localparam int CHANNEL_W   = 10;
   localparam int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) > 1) ? $clog2(DATA_IN_W / 8) : 1;
   localparam int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1;
   localparam int RATIO       = DATA_IN_W / DATA_OUT_W;
   localparam int IDX_W       = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;

   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(RATIO - 1);

   typedef logic [CHANNEL_W-1:0]   channel_t;
   typedef logic [EMPTY_IN_W-1:0]  empty_in_t;
   typedef logic [EMPTY_OUT_W-1:0] empty_out_t;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } state_t;

endpackage

// File: rtl/ast_width_downsizer_if.sv
// Avalon-ST stream bundle used on both sides of the width converter.
interface ast_width_downsizer_if
   import ast_conv_pkg::*;
#(
   parameter int DATA_W  = DATA_OUT_W,
   parameter int EMPTY_W = EMPTY_OUT_W,
   parameter int CHAN_W  = CHANNEL_W
) ();

   // A beat transfers on a rising clock edge where valid and ready are both high;
   // ready latency is 0 and the source holds every field stable until it transfers.
   logic [DATA_W-1:0]  data;
   logic [EMPTY_W-1:0] empty;
   logic [CHAN_W-1:0]  channel;
   logic               startofpacket;
   logic               endofpacket;
   logic               valid;
   logic               ready;

   modport master (
      output data, empty, channel, startofpacket, endofpacket, valid,
      input  ready
   );

   modport slave (
      input  data, empty, channel, startofpacket, endofpacket, valid,
      output ready
   );

endinterface

// File: rtl/ast_width_downsizer_slicer.sv
// Selects output beat idx (first symbol in MSBs) from the held wide word and
// derives the last beat index and trailing empty count of that word.
module ast_beat_slicer
   import ast_conv_pkg::*;
(
   input  logic [DATA_IN_W-1:0]  word,
   input  logic [IDX_W-1:0]      idx,
   input  logic                  eop,
   input  empty_in_t             empty,
   output logic [DATA_OUT_W-1:0] beat,
   output logic [IDX_W-1:0]      last_idx,
   output empty_out_t            last_empty
);

   logic [IDX_W-1:0] drop;

   always_comb begin
      beat = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (idx == IDX_W'(i)) begin
            beat = word[DATA_IN_W-1-i*DATA_OUT_W -: DATA_OUT_W];
         end
      end
   end

   // Whole empty output beats at the tail of an eop word are never sent.
   assign drop       = IDX_W'(empty >> EMPTY_OUT_W);
   assign last_idx   = eop ? (MAX_IDX - drop) : MAX_IDX;
   assign last_empty = empty[EMPTY_OUT_W-1:0];

endmodule

// File: rtl/ast_width_downsizer.sv
// Avalon-ST width down-converter: holds one wide word and replays it as RATIO
// narrow beats, reloading on the last beat so the output runs at full rate.
module ast_width_downsizer
   import ast_conv_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   ast_width_downsizer_if.slave  ast_in,
   ast_width_downsizer_if.master ast_out,
   output state_t                dbg_state
);

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [DATA_IN_W-1:0]   hold_data;
   empty_in_t              hold_empty;
   channel_t               hold_channel;
   logic                   hold_sop;
   logic                   hold_eop;

   logic [DATA_OUT_W-1:0]  beat;
   logic [IDX_W-1:0]       last_idx;
   empty_out_t             last_empty;
   logic                   sending;
   logic                   on_last;
   logic                   accept;

   ast_beat_slicer u_slicer (
      .word       (hold_data),
      .idx        (idx),
      .eop        (hold_eop),
      .empty      (hold_empty),
      .beat       (beat),
      .last_idx   (last_idx),
      .last_empty (last_empty)
   );

   assign sending = (state == SEND);
   assign on_last = sending && (idx == last_idx);

   // ready_i -> ready_o is the only combinational path through the block.
   assign ast_in.ready = (state == EMPTY) || (on_last && ast_out.ready);
   assign accept       = ast_in.valid && ast_in.ready;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= EMPTY;
         idx          <= '0;
         hold_data    <= '0;
         hold_empty   <= '0;
         hold_channel <= '0;
         hold_sop     <= 1'b0;
         hold_eop     <= 1'b0;
      end else begin
         if (accept) begin
            hold_data    <= ast_in.data;
            hold_empty   <= ast_in.empty;
            hold_channel <= ast_in.channel;
            hold_sop     <= ast_in.startofpacket;
            hold_eop     <= ast_in.endofpacket;
         end
         case (state)
            EMPTY: begin
               if (accept) begin
                  state <= SEND;
                  idx   <= '0;
               end
            end
            SEND: begin
               if (ast_out.ready) begin
                  if (idx != last_idx) begin
                     idx <= idx + 1'b1;
                  end else if (accept) begin
                     idx <= '0;
                  end else begin
                     state <= EMPTY;
                     idx   <= '0;
                  end
               end
            end
            default: begin
               state <= EMPTY;
               idx   <= '0;
            end
         endcase
      end
   end

   assign ast_out.valid         = sending;
   assign ast_out.data          = beat;
   assign ast_out.channel       = hold_channel;
   assign ast_out.startofpacket = sending && hold_sop && (idx == '0);
   assign ast_out.endofpacket   = on_last && hold_eop;
   assign ast_out.empty         = (on_last && hold_eop) ? last_empty : '0;

   assign dbg_state = state;

endmodule

// File: tb/tb_ast_width_downsizer.sv
// Scoreboard bench for the 128->64 Avalon-ST width down-converter.
module tb_ast_width_downsizer;
   import ast_conv_pkg::*;

   localparam int EXP_W = 1 + 1 + 1 + EMPTY_OUT_W + CHANNEL_W + DATA_OUT_W;

   logic   clk;
   logic   rst_n;
   state_t dbg_state;

   ast_width_downsizer_if #(.DATA_W(DATA_IN_W),  .EMPTY_W(EMPTY_IN_W))  in_if ();
   ast_width_downsizer_if #(.DATA_W(DATA_OUT_W), .EMPTY_W(EMPTY_OUT_W)) out_if ();

   ast_width_downsizer dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .ast_in    (in_if.slave),
      .ast_out   (out_if.master),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // expected entry: {word_last, sop, eop, empty, channel, data}
   logic [EXP_W-1:0] exp_q[$];

   logic rand_mode   = 1'b0;
   logic ready_level = 1'b1;

   logic        win_on  = 1'b0;
   int          win_cnt = 0;
   int          win_first = 0;
   int          win_last  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [EXP_W-1:0] mk(input logic wl, input logic s, input logic e,
                                          input logic [EMPTY_OUT_W-1:0] em, input logic [CHANNEL_W-1:0] ch,
                                          input logic [DATA_OUT_W-1:0] d);
      return {wl, s, e, em, ch, d};
   endfunction

   // reference model for randomised words: 128-bit word -> one or two 64-bit beats
   task automatic push_model(input logic [127:0] w, input logic s, input logic e,
                             input logic [3:0] em, input logic [9:0] ch);
      int nb;
      nb = e ? (2 - int'(em[3])) : 2;
      for (int b = 0; b < nb; b++) begin
         exp_q.push_back(mk(b == nb - 1, s && (b == 0), e && (b == nb - 1),
                            (e && (b == nb - 1)) ? em[2:0] : 3'd0, ch,
                            (b == 0) ? w[127:64] : w[63:0]));
      end
   endtask

   // driver: called just after a negedge, returns just after the negedge following accept
   task automatic send_word(input logic [127:0] w, input logic s, input logic e,
                            input logic [3:0] em, input logic [9:0] ch);
      logic got;
      int   n;
      in_if.data          = w;
      in_if.startofpacket = s;
      in_if.endofpacket   = e;
      in_if.empty         = em;
      in_if.channel       = ch;
      in_if.valid         = 1'b1;
      n = 0;
      forever begin
         #1 got = in_if.ready;
         @(posedge clk);
         if (got) break;
         n++;
         if (n > 500) begin
            chk("accept_timeout", 1'b0, 1'b1);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      in_if.valid         = 1'b0;
      in_if.startofpacket = 1'b0;
      in_if.endofpacket   = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, 128'(exp_q.size()), 128'd0);
      @(negedge clk);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // downstream ready driver: only writer of out_if.ready
   always @(negedge clk) begin
      out_if.ready <= rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
   end

   // monitor: pops and compares whenever the DUT presents a transferring beat
   logic [EXP_W-1:0] cur;
   logic [EXP_W-1:0] prev_beat;
   logic             prev_stall = 1'b0;
   logic [EXP_W-1:0] e;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            cur = mk(1'b0, out_if.startofpacket, out_if.endofpacket, out_if.empty,
                     out_if.channel, out_if.data);
            if (prev_stall && out_if.valid) begin
               chk("stall_stable", 128'(cur), 128'(prev_beat));
            end
            if (out_if.valid && out_if.ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 128'(cur), 128'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("ready_o", 128'(in_if.ready), 128'(e[EXP_W-1]));
                  chk("beat", 128'(cur), 128'({1'b0, e[EXP_W-2:0]}));
               end
               if (win_on) begin
                  if (win_cnt == 0) win_first = cyc;
                  win_last = cyc;
                  win_cnt++;
               end
            end else if (!out_if.valid) begin
               chk("ready_o_idle", 128'(in_if.ready), 128'd1);
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_beat  = cur;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      logic [127:0] w;
      logic         s;
      logic         eo;
      logic [3:0]   em;

      rst_n = 1'b0;
      idle();
      in_if.data    = '0;
      in_if.empty   = '0;
      in_if.channel = '0;
      out_if.ready  = 1'b1;
      #3;
      chk("rst_valid", 128'(out_if.valid), 128'd0);
      chk("rst_ready", 128'(in_if.ready), 128'd1);
      chk("rst_sop_eop", 128'({out_if.startofpacket, out_if.endofpacket}), 128'd0);
      chk("rst_data", 128'(out_if.data), 128'd0);
      chk("rst_chan_empty", 128'({out_if.channel, out_if.empty}), 128'd0);
      chk("rst_state", 128'(dbg_state), 128'(EMPTY));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: two-beat sop+eop word, hand-computed beats
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 10'd5, 64'h0011223344556677));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 3'd0, 10'd5, 64'h8899AABBCCDDEEFF));
      send_word(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b1, 4'd0, 10'd5);
      idle();
      drain("t1_drain");

      // 2: eop with empty 11 -> single beat, empty_o 3; empty 8 -> single beat, empty_o 0
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 3'd3, 10'd9, 64'hDEADBEEF01234567));
      send_word(128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 1'b1, 1'b1, 4'd11, 10'd9);
      idle();
      drain("t2a_drain");
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 3'd0, 10'd10, 64'hCAFEF00D12345678));
      send_word(128'hCAFEF00D_12345678_AAAAAAAA_BBBBBBBB, 1'b0, 1'b1, 4'd8, 10'd10);
      idle();
      drain("t2b_drain");

      // 3: three-word packet back to back -> six beats without bubbles
      win_on = 1'b1; win_cnt = 0;
      push_model(128'h01010101_02020202_03030303_04040404, 1'b1, 1'b0, 4'd0, 10'd7);
      push_model(128'h05050505_06060606_07070707_08080808, 1'b0, 1'b0, 4'd0, 10'd7);
      push_model(128'h090A0B0C_0D0E0F10_11121314_15161718, 1'b0, 1'b1, 4'd2, 10'd7);
      send_word(128'h01010101_02020202_03030303_04040404, 1'b1, 1'b0, 4'd0, 10'd7);
      send_word(128'h05050505_06060606_07070707_08080808, 1'b0, 1'b0, 4'd0, 10'd7);
      send_word(128'h090A0B0C_0D0E0F10_11121314_15161718, 1'b0, 1'b1, 4'd2, 10'd7);
      idle();
      drain("t3_drain");
      win_on = 1'b0;
      chk("t3_beats", 128'(win_cnt), 128'd6);
      chk("t3_no_bubble", 128'(win_last - win_first), 128'd5);

      // 4: random downstream backpressure over random words
      rand_mode = 1'b1;
      for (int i = 0; i < 12; i++) begin
         w  = {$urandom, $urandom, $urandom, $urandom};
         s  = (i % 3) == 0;
         eo = (i % 3) == 2;
         em = 4'($urandom_range(0, 15));
         push_model(w, s, eo, em, 10'($urandom_range(0, 1023)));
         send_word(w, s, eo, em, exp_q[exp_q.size()-1][DATA_OUT_W +: CHANNEL_W]);
         if ($urandom_range(0, 1) == 1) begin
            idle();
            @(negedge clk);
         end
      end
      idle();
      drain("t4_drain");
      rand_mode = 1'b0;
      @(negedge clk);

      // 5: async reset after beat0, with beat1 stalled
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 10'd3, 64'h1111111122222222));
      send_word(128'h11111111_22222222_33333333_44444444, 1'b1, 1'b1, 4'd0, 10'd3);
      idle();
      @(posedge clk);
      #1 ready_level = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_valid_async", 128'(out_if.valid), 128'd0);
      chk("t5_ready", 128'(in_if.ready), 128'd1);
      chk("t5_state", 128'(dbg_state), 128'(EMPTY));
      chk("t5_beat0_seen", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ready_level = 1'b1;
      repeat (3) @(negedge clk);
      push_model(128'h55555555_66666666_77777777_88888888, 1'b1, 1'b1, 4'd4, 10'd12);
      send_word(128'h55555555_66666666_77777777_88888888, 1'b1, 1'b1, 4'd4, 10'd12);
      idle();
      drain("t5_drain");

      // 6: back-to-back single-beat eop words with distinct channels
      win_on = 1'b1; win_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 3'(i), 10'(100 + i), 64'hA0A0A0A0_00000000 + 64'(i)));
      end
      for (int i = 0; i < 4; i++) begin
         send_word({64'hA0A0A0A0_00000000 + 64'(i), 64'hFFFFFFFF_FFFFFFFF}, 1'b1, 1'b1,
                   4'(8 + i), 10'(100 + i));
      end
      idle();
      drain("t6_drain");
      win_on = 1'b0;
      chk("t6_beats", 128'(win_cnt), 128'd4);
      chk("t6_one_per_cycle", 128'(win_last - win_first), 128'd3);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
